// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - tagged command FIFO that issues one op at a time to a shared ALU
// Define ILLEGAL_OP_CHECK_EN to answer unknown opcodes with rsp_err instead of issuing them.
module alu_cmd_issuer #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int ALU_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam logic [PW:0]   FULL_LVL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(ALU_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             head;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push, pop;
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [31:0]      alu_a_q, alu_b_q, rsp_result_q;
  logic [3:0]       alu_op_q;
  logic             rsp_valid_q, rsp_zero_q;
  logic [TAG_W-1:0] rsp_tag_q;

`ifdef ILLEGAL_OP_CHECK_EN
  logic rsp_err_q;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1001, 4'b1010: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = (count_q != FULL_LVL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  // Storage is never read before it is written, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
`ifdef ILLEGAL_OP_CHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            rsp_tag_q <= head.tag;
            cnt_q     <= '0;
`ifdef ILLEGAL_OP_CHECK_EN
            if (!op_legal(head.op)) begin
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end else begin
              rsp_err_q <= 1'b0;
              alu_a_q   <= head.a;
              alu_b_q   <= head.b;
              alu_op_q  <= head.op;
              state_q   <= ISSUE;
            end
`else
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            alu_op_q <= head.op;
            state_q  <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_tag    = rsp_tag_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - randomized bench for alu_cmd_issuer with a queue-based reference model
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int W     = 3;
  localparam logic [3:0] LEGAL [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [31:0]      cmd_a = '0, cmd_b = '0;
  logic [3:0]       cmd_op = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready = 1'b0, rsp_zero, rsp_err, busy;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ALU_WAIT(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return ~a;
      4'h9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hA:    return a * b;
      default: return 32'hBAD0_0000 | {28'd0, op};
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero   = (alu_result == 32'd0);

  typedef struct {
    logic [31:0]      a, b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             zero, err;
  } exp_t;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.tag = tag;
    e.res = alu_fn(a, b, op);
    e.zero = (e.res == 32'd0);
    e.err = 1'b0;
`ifdef ILLEGAL_OP_CHECK_EN
    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA})) begin
      e.res = '0; e.zero = 1'b0; e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  exp_t             exp_q [$];
  logic [31:0]      got_res [$];
  logic             got_zero [$], got_err [$];
  logic [TAG_W-1:0] got_tag [$];
  int               cycle = 0, push_cyc = 0, last_rsp_cyc = 0;
  logic [TAG_W-1:0] tag_ctr = 1;
  bit               rand_rdy = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Response monitor: ordering, payload, hold under backpressure and ALU drive stability.
  logic [67:0] cur_alu, prev_alu = '0, last_iss = '0;
  logic [63:0] hold_v = '0;
  logic        pv = 1'b0, pr = 1'b0;
  int          stable = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; stable = 0; prev_alu = '0; last_iss = '0;
    end else begin
      cur_alu = {alu_a, alu_b, alu_op};
      if (cur_alu != prev_alu) stable = 0;
      else stable++;
      prev_alu = cur_alu;
      if (pv && !pr)
        check("rsp_hold", 128'({rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err}), 128'(hold_v));
      if (rsp_valid && !pv) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 128'(1), 128'(0));
        else if (!exp_q[0].err) begin
          check("alu_stable", 128'(stable >= W), 128'(1));
          check("alu_drive", 128'(cur_alu), 128'({exp_q[0].a, exp_q[0].b, exp_q[0].op}));
        end else check("alu_keep", 128'(cur_alu), 128'(last_iss));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp_hs", 128'(1), 128'(0));
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_result", 128'(rsp_result), 128'(e.res));
          check("rsp_zero", 128'(rsp_zero), 128'(e.zero));
          check("rsp_tag", 128'(rsp_tag), 128'(e.tag));
          check("rsp_err", 128'(rsp_err), 128'(e.err));
          if (!e.err) last_iss = {e.a, e.b, e.op};
        end
        got_res.push_back(rsp_result);
        got_zero.push_back(rsp_zero);
        got_err.push_back(rsp_err);
        got_tag.push_back(rsp_tag);
        last_rsp_cyc = cycle;
      end
      pv = rsp_valid; pr = rsp_ready;
      hold_v = 64'({rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err});
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit hs = 1'b0;
    int n = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag_ctr;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = cmd_ready;
      if (hs) push_cyc = cycle;
      n++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!hs) check("push_timeout", 128'(0), 128'(1));
    else begin
      exp_q.push_back(model(a, b, op, tag_ctr));
      tag_ctr++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(n < 3000), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic clear_got();
    got_res.delete(); got_zero.delete(); got_err.delete(); got_tag.delete();
  endtask

  task automatic check_reset_outs();
    check("rst_ctrl", 128'({cmd_ready, rsp_valid, rsp_zero, rsp_err, busy}), 128'(5'b10000));
    check("rst_alu", 128'({alu_a, alu_b, alu_op}), 128'(0));
    check("rst_rsp", 128'({rsp_result, rsp_tag}), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // 1: ADD latency and payload
    clear_got();
    push_cmd(32'd5, 32'd3, 4'h0);
    wait_idle();
    check("t1_latency", 128'(last_rsp_cyc - push_cyc), 128'(W + 2));
    check("t1_result", 128'(got_res[0]), 128'(32'd8));
    check("t1_zero", 128'(got_zero[0]), 128'(0));
    check("t1_tag", 128'(got_tag[0]), 128'(1));

    // 2: back-to-back SUB then MUL
    clear_got();
    push_cmd(32'd5, 32'd5, 4'h1);
    push_cmd(32'd5, 32'd3, 4'hA);
    wait_idle();
    check("t2_sub", 128'({got_res[0], got_zero[0]}), 128'({32'd0, 1'b1}));
    check("t2_mul", 128'({got_res[1], got_zero[1]}), 128'({32'h0000000F, 1'b0}));

    // 4: NOT, SLT, XOR
    clear_got();
    push_cmd(32'h0000000A, 32'd0, 4'h5);
    push_cmd(32'd3, 32'd5, 4'h9);
    push_cmd(32'h0000000A, 32'h3, 4'h4);
    wait_idle();
    check("t4_not", 128'(got_res[0]), 128'(32'hFFFFFFF5));
    check("t4_slt", 128'(got_res[1]), 128'(32'd1));
    check("t4_xor", 128'(got_res[2]), 128'(32'd9));

    // 6: unlisted opcode
    clear_got();
    push_cmd(32'd1, 32'd2, 4'h7);
    wait_idle();
`ifdef ILLEGAL_OP_CHECK_EN
    check("t6_err", 128'({got_err[0], got_res[0]}), 128'({1'b1, 32'd0}));
    check("t6_alu_op", 128'(alu_op), 128'(4'h4));
`else
    check("t6_err", 128'({got_err[0], got_res[0]}), 128'({1'b0, 32'hBAD00007}));
    check("t6_alu_op", 128'(alu_op), 128'(4'h7));
`endif

    // 3: fill under backpressure, then drain in order
    clear_got();
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_cmd($urandom, $urandom, LEGAL[i % 8]);
    @(negedge clk);
    check("t3_full", 128'({cmd_ready, busy, rsp_valid}), 128'(3'b011));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();
    check("t3_count", 128'(got_res.size()), 128'(DEPTH + 1));

    // random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rop = ($urandom_range(0, 4) != 0) ? LEGAL[$urandom_range(0, 7)] : 4'($urandom_range(0, 15));
      push_cmd(ra, rb, rop);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    wait_idle();

    // 5: reset while issuing with two queued
    clear_got();
    push_cmd(32'd1, 32'd1, 4'h0);
    push_cmd(32'd2, 32'd2, 4'h0);
    push_cmd(32'd3, 32'd3, 4'h0);
    check("t5_busy", 128'({busy, rsp_valid}), 128'(2'b10));
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outs();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_no_rsp", 128'({got_res.size(), busy}), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
